keyboard_event_controller: RTL and testbench
============================================

# keyboard_event_controller

Sequences the decoded keyboard state vector produced by the matrix scan decoder into a stream of discrete key events. The block synchronises and debounces the whole key vector, then walks it key by key against the last reported state. Each press or release is pushed into a small event FIFO, which system logic drains through a valid/ready handshake. It sits between the keyboard decoder and any consumer (CPU bus bridge, display logic).

## Interface
- KEY_COUNT, 16, number of keys in the decoded vector.
- KEY_INDEX_WIDTH, 4, width of a key index; must satisfy 2^KEY_INDEX_WIDTH >= KEY_COUNT.
- SAMPLE_DIV, 50000, clk cycles between debounce samples; must be >= 2.
- DEBOUNCE_SAMPLES, 4, consecutive identical samples required to accept a new vector; must be >= 2.
- FIFO_DEPTH, 4, event FIFO entries; must be a power of two.
- FIFO_PTR_WIDTH, 2, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock; the only clock in the block.
- reset_n  in  1  asynchronous, active-low reset.
- keys  in  KEY_COUNT  decoded key vector, active-low: bit = 0 means pressed. Treated as asynchronous.
- event_key  out  KEY_INDEX_WIDTH  index of the key at the FIFO head.
- event_pressed  out  1  1 = press event, 0 = release event.
- event_valid  out  1  FIFO non-empty; event_key/event_pressed valid.
- event_ready  in  1  consumer accepts the head event.
- busy  out  1  FSM is in SCAN.

## Operation
- Synchroniser: keys passes through two flops (sync_keys). Reset value is all ones.
- Prescaler: counts 0..SAMPLE_DIV-1 and wraps. It issues a one-cycle sample tick on the wrap.
- Debounce runs on each tick:
  - If sync_keys == candidate: count increments, saturating at DEBOUNCE_SAMPLES-1. When count is already DEBOUNCE_SAMPLES-1, stable <= candidate.
  - If sync_keys != candidate: candidate <= sync_keys and count <= 0.
  - Reset values: candidate = stable = all ones, count = 0.
- reported holds the last state pushed for each key. Reset value is all ones.
- FSM state IDLE:
  - Enters SCAN with idx <= 0 when stable != reported. Otherwise stays in IDLE.
- FSM state SCAN (one key per cycle):
  - If stable[idx] == reported[idx]: no push.
  - If they differ and the FIFO is not full: push {idx, ~stable[idx]} and set reported[idx] <= stable[idx].
  - If they differ and the FIFO is full: stall, holding idx with no push.
  - When idx == KEY_COUNT-1 and it did not stall, return to IDLE. Otherwise idx increments.
  - stable may change during a scan. The current stable bit is always the one compared, so no change is lost; residual mismatches trigger a new scan from IDLE.
- Events are never dropped. Back-pressure stalls the scan. Debouncing continues during a stall.
- FIFO behaviour:
  - First-word-fall-through. event_valid = (occupancy != 0). Pop occurs on event_valid && event_ready.
  - Push is blocked whenever occupancy == FIFO_DEPTH, even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full leaves occupancy unchanged.
  - Occupancy counter is FIFO_PTR_WIDTH+1 bits. Pointers wrap modulo FIFO_DEPTH.
- Reset at any time, including mid-scan or with the FIFO non-empty:
  - Forces IDLE, empties the FIFO, and restores all reset values.
  - No event is emitted for keys held down across reset until their debounced state differs from all ones.

## Timing
- Reset values: event_valid = 0, event_key = 0, event_pressed = 0, busy = 0.
- Input to stable: 2 synchroniser cycles, then DEBOUNCE_SAMPLES ticks. stable updates on the clock edge at the end of the accepting tick cycle.
- stable to event:
  - SCAN is entered 1 cycle after stable changes. busy goes high in that cycle.
  - Key i is examined in SCAN cycle i, counting from 0.
  - event_valid rises 1 cycle after the push.
- Scan duration is KEY_COUNT cycles plus stall cycles. busy falls the cycle after the last key is examined.
- Handshake: event_key and event_pressed are stable while event_valid && !event_ready. Sustained throughput is one event per cycle.

## Test plan
- Settings for all tests: SAMPLE_DIV = 4, DEBOUNCE_SAMPLES = 3, KEY_COUNT = 16, FIFO_DEPTH = 4.
- Reset then idle: keys = 16'hFFFF for 200 cycles -> event_valid and busy stay 0; all outputs are 0 throughout reset.
- Single press and release: keys = 16'hFFF7 held steady, event_ready = 1 -> exactly one event {key 3, pressed 1}. keys back to 16'hFFFF -> exactly one event {key 3, pressed 0}.
- Bounce rejection: bit 5 toggles at every sample tick for 20 ticks, then settles at 0 -> no event during toggling; one event {5, 1} after 3 stable ticks.
- Back-pressure: with event_ready = 0, keys = 16'h00FF (keys 8..15 pressed) -> 4 events {8..11, 1} queued; busy stays 1 with idx stalled at 12. Raise event_ready -> 8 events in ascending order 8..15, none lost or duplicated.
- Simultaneous push/pop at full: with FIFO full and event_ready pulsed for 1 cycle -> occupancy drops to 3 that cycle and the push occurs on the following cycle; event order is preserved.
- Reset mid-scan: assert reset_n = 0 while busy = 1 with 2 events queued -> event_valid = 0 and busy = 0 immediately. After release with keys = 16'hFFFF, no events appear.

Source files
------------

// File: rtl/keyboard_event_controller.sv
// Keyboard event sequencer: sync, debounce, scan, and FWFT event FIFO.
// Turns a decoded active-low key vector into press/release events.
module keyboard_event_controller #(
  parameter int KEY_COUNT        = 16,
  parameter int KEY_INDEX_WIDTH  = 4,
  parameter int SAMPLE_DIV       = 50000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int FIFO_DEPTH       = 4,
  parameter int FIFO_PTR_WIDTH   = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [KEY_COUNT-1:0]       keys,
  output logic [KEY_INDEX_WIDTH-1:0] event_key,
  output logic                       event_pressed,
  output logic                       event_valid,
  input  logic                       event_ready,
  output logic                       busy
);

  localparam int SDW = $clog2(SAMPLE_DIV);
  localparam int DCW = $clog2(DEBOUNCE_SAMPLES);
  localparam int KIW = KEY_INDEX_WIDTH;
  localparam int FPW = FIFO_PTR_WIDTH;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  logic [KEY_COUNT-1:0] meta;
  logic [KEY_COUNT-1:0] sync_keys;
  logic [KEY_COUNT-1:0] candidate;
  logic [KEY_COUNT-1:0] stable;
  logic [KEY_COUNT-1:0] reported;
  logic [SDW-1:0]       div_cnt;
  logic [DCW-1:0]       deb_cnt;
  logic                 tick;

  state_t               state;
  logic [KIW-1:0]       idx;
  logic                 differ;
  logic                 last;

  logic [KIW:0]         mem [FIFO_DEPTH];
  logic [FPW-1:0]       wr_ptr;
  logic [FPW-1:0]       rd_ptr;
  logic [FPW:0]         occ;
  logic                 full;
  logic                 push;
  logic                 pop;

  assign tick   = (div_cnt == SDW'(SAMPLE_DIV - 1));
  assign differ = (stable[idx] != reported[idx]);
  assign last   = (idx == KIW'(KEY_COUNT - 1));
  assign full   = (occ == (FPW+1)'(FIFO_DEPTH));
  assign push   = (state == SCAN) && differ && !full;
  assign pop    = event_valid && event_ready;

  assign event_valid = (occ != '0);
  assign busy        = (state == SCAN);
  assign {event_key, event_pressed} = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta      <= '1;
      sync_keys <= '1;
    end else begin
      meta      <= keys;
      sync_keys <= meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + SDW'(1);
    end
  end

  // count saturates; once saturated, each matching tick re-commits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate <= '1;
      stable    <= '1;
      deb_cnt   <= '0;
    end else if (tick) begin
      if (sync_keys == candidate) begin
        if (deb_cnt == DCW'(DEBOUNCE_SAMPLES - 1)) begin
          stable <= candidate;
        end else begin
          deb_cnt <= deb_cnt + DCW'(1);
        end
      end else begin
        candidate <= sync_keys;
        deb_cnt   <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      reported <= '1;
    end else begin
      unique case (state)
        IDLE: begin
          if (stable != reported) begin
            state <= SCAN;
            idx   <= '0;
          end
        end
        SCAN: begin
          // a full FIFO holds idx until a slot frees
          if (!differ || !full) begin
            if (differ) begin
              reported[idx] <= stable[idx];
            end
            if (last) begin
              state <= IDLE;
            end else begin
              idx <= idx + KIW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {idx, ~stable[idx]};
        wr_ptr      <= wr_ptr + FPW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FPW'(1);
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + (FPW+1)'(1);
        2'b01:   occ <= occ - (FPW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_keyboard_event_controller.sv
// Bench for keyboard_event_controller: vector table plus scoreboard
// of expected events, with hand sequences for stall and reset cases.
module tb_keyboard_event_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] keys;
  logic [3:0]  event_key;
  logic        event_pressed;
  logic        event_valid;
  logic        event_ready;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int seen = 0;
  logic [4:0] exp_q[$];

  typedef struct {
    logic [15:0] keys;
    int          n_ev;
  } vec_t;

  vec_t vt[7];

  always #5 clk = ~clk;

  keyboard_event_controller #(
    .KEY_COUNT(16),
    .KEY_INDEX_WIDTH(4),
    .SAMPLE_DIV(4),
    .DEBOUNCE_SAMPLES(3),
    .FIFO_DEPTH(4),
    .FIFO_PTR_WIDTH(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .keys(keys),
    .event_key(event_key),
    .event_pressed(event_pressed),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .busy(busy)
  );

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // sample at negedge, then step to just after the next posedge
  task automatic cyc(input int n);
    logic [4:0] e;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (reset_n && event_valid && event_ready) begin
        seen++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event got key=%0d pressed=%0d want none",
                   event_key, event_pressed);
        end else begin
          e = exp_q.pop_front();
          if ({event_key, event_pressed} !== e) begin
            miscompares++;
            $display("FAIL event got key=%0d pressed=%0d want key=%0d pressed=%0d",
                     event_key, event_pressed, e[4:1], e[0]);
          end
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_diff(input logic [15:0] prev, input logic [15:0] nxt);
    for (int i = 0; i < 16; i++) begin
      if (prev[i] != nxt[i]) exp_q.push_back({4'(i), ~nxt[i]});
    end
  endtask

  initial begin
    int q;
    int s0;
    int budget;
    logic [15:0] prev;

    vt[0] = '{16'hFFF7, 1};
    vt[1] = '{16'hFFFF, 1};
    vt[2] = '{16'h00FF, 8};
    vt[3] = '{16'hFFFF, 8};
    vt[4] = '{16'h8001, 14};
    vt[5] = '{16'h7FFE, 16};
    vt[6] = '{16'hFFFF, 2};

    reset_n     = 1'b0;
    keys        = 16'hFFFF;
    event_ready = 1'b0;
    cyc(3);
    check("rst_valid", event_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_key", event_key, 0);
    check("rst_pressed", event_pressed, 0);

    reset_n = 1'b1;
    q = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1);
      if (event_valid || busy) q++;
    end
    check("idle_quiet", q, 0);

    event_ready = 1'b1;
    prev = 16'hFFFF;
    for (int v = 0; v < 7; v++) begin
      s0 = seen;
      expect_diff(prev, vt[v].keys);
      keys = vt[v].keys;
      prev = vt[v].keys;
      cyc(90);
      check($sformatf("vec%0d_events", v), seen - s0, vt[v].n_ev);
      check($sformatf("vec%0d_drained", v), exp_q.size(), 0);
      check($sformatf("vec%0d_busy", v), busy, 0);
    end

    s0 = seen;
    for (int t = 0; t < 20; t++) begin
      keys[5] = ~keys[5];
      cyc(4);
    end
    check("bounce_none", seen - s0, 0);
    keys[5] = 1'b0;
    exp_q.push_back({4'd5, 1'b1});
    cyc(80);
    check("bounce_press", seen - s0, 1);
    keys = 16'hFFFF;
    exp_q.push_back({4'd5, 1'b0});
    cyc(80);
    check("bounce_release", seen - s0, 2);

    event_ready = 1'b0;
    s0 = seen;
    expect_diff(16'hFFFF, 16'h00FF);
    keys = 16'h00FF;
    cyc(70);
    check("bp_occ", dut.occ, 4);
    check("bp_idx", dut.idx, 12);
    check("bp_busy", busy, 1);
    check("bp_head", event_key, 8);
    event_ready = 1'b1;
    cyc(1);
    event_ready = 1'b0;
    check("full_pop_occ", dut.occ, 3);
    check("full_pop_idx", dut.idx, 12);
    cyc(1);
    check("full_push_occ", dut.occ, 4);
    check("full_push_idx", dut.idx, 13);
    event_ready = 1'b1;
    cyc(80);
    check("bp_events", seen - s0, 8);
    check("bp_drained", exp_q.size(), 0);
    s0 = seen;
    expect_diff(16'h00FF, 16'hFFFF);
    keys = 16'hFFFF;
    cyc(80);
    check("bp_release", seen - s0, 8);

    event_ready = 1'b0;
    keys = 16'hFFFC;
    budget = 0;
    while (!busy && budget < 100) begin
      cyc(1);
      budget++;
    end
    check("mid_busy_seen", busy, 1);
    cyc(2);
    check("mid_occ", dut.occ, 2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", event_valid, 0);
    check("mid_rst_busy", busy, 0);
    exp_q.delete();
    keys = 16'hFFFF;
    cyc(3);
    reset_n = 1'b1;
    event_ready = 1'b1;
    s0 = seen;
    q = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1);
      if (event_valid || busy) q++;
    end
    check("post_rst_events", seen - s0, 0);
    check("post_rst_quiet", q, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
